// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester byte FIFO arbiter feeding a single RS232 transmitter.
// Ports:
//   clk, rst_in           - clock, asynchronous active-low reset
//   wrData0/wrEn0         - push port of requester 0 (RX echo path)
//   wrData1/wrEn1         - push port of requester 1 (CPU port)
//   txBusy                - busy flag from the transmitter
//   txData/txStart        - byte and one-cycle start pulse to the transmitter
//   full0/full1           - FIFO n holds DEPTH bytes
//   ovf0/ovf1, ovfClr     - sticky dropped-push flags and their clear
//   timeoutErr            - sticky: transmitter never acknowledged a start (cleared by ovfClr)
module uart_tx_arbiter #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [7:0] wrData0,
    input  logic       wrEn0,
    input  logic [7:0] wrData1,
    input  logic       wrEn1,
    input  logic       txBusy,
    output logic [7:0] txData,
    output logic       txStart,
    output logic       full0,
    output logic       full1,
    output logic       ovf0,
    output logic       ovf1,
    input  logic       ovfClr,
    output logic       timeoutErr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_e;

    state_e        state_q;
    logic [7:0]    mem_q [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [CW-1:0] cnt_q [2];
    logic [1:0]    ovf_q, ovf_d;
    logic          grant_q, last_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    tx_data_q;
    logic          tx_start_q, tmo_err_q, tmo_err_d, tmo_hit;
    logic [7:0]    wr_data [2];
    logic [1:0]    wr_en, ne, pop, push, drop;

    assign wr_data[0] = wrData0;
    assign wr_data[1] = wrData1;
    assign wr_en      = {wrEn1, wrEn0};

    // A full FIFO still accepts a push in the cycle its head is popped by LOAD.
    always_comb begin
        ne   = '0;
        pop  = '0;
        push = '0;
        drop = '0;
        for (int i = 0; i < 2; i++) begin
            ne[i]   = cnt_q[i] != '0;
            pop[i]  = state_q == LOAD && grant_q == 1'(i);
            push[i] = wr_en[i] && (cnt_q[i] != CW'(DEPTH) || pop[i]);
            drop[i] = wr_en[i] && !push[i];
        end
    end

    // Clear wins over a same-cycle set for all sticky flags.
    assign ovf_d     = ovfClr ? 2'b00 : (ovf_q | drop);
    assign tmo_hit   = state_q == WAIT_ACK && !txBusy && tmo_q == TW'(ACK_TIMEOUT - 1);
    assign tmo_err_d = !ovfClr && (tmo_err_q || tmo_hit);

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= wr_data[i];
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            tmo_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            ovf_q      <= 2'b00;
        end else begin
            tx_start_q <= 1'b0;
            ovf_q      <= ovf_d;
            tmo_err_q  <= tmo_err_d;
            case (state_q)
                IDLE: if (|ne && !txBusy) begin
                    state_q <= LOAD;
                    // Both pending: alternate; otherwise the only non-empty one.
                    grant_q <= &ne ? ~last_q : ~ne[0];
                end
                LOAD: begin
                    tx_data_q  <= mem_q[grant_q][rd_ptr_q[grant_q]];
                    tx_start_q <= 1'b1;
                    last_q     <= grant_q;
                    tmo_q      <= '0;
                    state_q    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (txBusy) state_q <= WAIT_DONE;
                    else if (tmo_hit) state_q <= IDLE;
                    else tmo_q <= tmo_q + 1'b1;
                end
                WAIT_DONE: if (!txBusy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign txData     = tx_data_q;
    assign txStart    = tx_start_q;
    assign full0      = cnt_q[0] == CW'(DEPTH);
    assign full1      = cnt_q[1] == CW'(DEPTH);
    assign ovf0       = ovf_q[0];
    assign ovf1       = ovf_q[1];
    assign timeoutErr = tmo_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_uart_tx_arbiter;
    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 15;

    logic       clk = 1'b0, rst_in = 1'b1;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       wr0 = 1'b0, wr1 = 1'b0, busy = 1'b0, clr = 1'b0;
    logic [7:0] txData;
    logic       txStart, full0, full1, ovf0, ovf1, timeoutErr;

    uart_tx_arbiter #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst_in(rst_in),
        .wrData0(d0), .wrEn0(wr0), .wrData1(d1), .wrEn1(wr1),
        .txBusy(busy), .txData(txData), .txStart(txStart),
        .full0(full0), .full1(full1), .ovf0(ovf0), .ovf1(ovf1),
        .ovfClr(clr), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] sent [$];

    // Model: byte queues per requester plus the life of the one transfer in flight.
    logic [7:0] mq0 [$], mq1 [$];
    int   m_src, m_age, m_last;
    bit   m_done;
    logic [7:0] e_data;
    logic e_start, e_ovf0, e_ovf1, e_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        m_src = -1; m_age = -1; m_last = 1; m_done = 0;
        e_data = 8'h00; e_start = 0; e_ovf0 = 0; e_ovf1 = 0; e_err = 0;
    endtask

    function automatic bit model_idle();
        return mq0.size() == 0 && mq1.size() == 0 && m_src < 0 && m_age < 0 && !m_done;
    endfunction

    // One clock edge: m_src is a granted source whose start happens at this edge,
    // m_age counts cycles since the start while no acknowledge has been seen.
    task automatic model_step();
        bit drop0, drop1, tmo;
        if (!rst_in) begin
            model_reset();
            return;
        end
        e_start = 0;
        tmo = 0;
        if (m_src >= 0) begin
            if (m_src == 0) e_data = mq0.pop_front();
            else e_data = mq1.pop_front();
            m_last = m_src; m_src = -1; m_age = 0; e_start = 1;
        end else if (m_age >= 0) begin
            m_age++;
            if (busy) begin m_age = -1; m_done = 1; end
            else if (m_age == ACK_TIMEOUT) begin m_age = -1; tmo = 1; end
        end else if (m_done) begin
            if (!busy) m_done = 0;
        end else if (!busy && (mq0.size() > 0 || mq1.size() > 0)) begin
            if (mq0.size() > 0 && mq1.size() > 0) m_src = 1 - m_last;
            else m_src = (mq0.size() > 0) ? 0 : 1;
        end
        drop0 = wr0 && mq0.size() >= DEPTH;
        drop1 = wr1 && mq1.size() >= DEPTH;
        if (wr0 && !drop0) mq0.push_back(d0);
        if (wr1 && !drop1) mq1.push_back(d1);
        e_ovf0 = !clr && (e_ovf0 || drop0);
        e_ovf1 = !clr && (e_ovf1 || drop1);
        e_err  = !clr && (e_err || tmo);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        chk("txStart", txStart, e_start);
        chk("txData", txData, e_data);
        chk("full0", full0, mq0.size() == DEPTH);
        chk("full1", full1, mq1.size() == DEPTH);
        chk("ovf0", ovf0, e_ovf0);
        chk("ovf1", ovf1, e_ovf1);
        chk("timeoutErr", timeoutErr, e_err);
        if (txStart === 1'b1) sent.push_back(txData);
    end

    // Transmitter stand-in: after a start, busy rises after a short delay (sometimes too late).
    bit auto_busy = 0, glitch = 0;
    int r_dly = 0, r_len = 0;

    task automatic tick();
        @(negedge clk);
        if (auto_busy) begin
            if (txStart === 1'b1) begin
                r_dly = ($urandom_range(0, 7) == 0) ? ACK_TIMEOUT + 3 : int'($urandom_range(1, 4));
                r_len = $urandom_range(1, 5);
            end
            if (r_dly > 0) begin
                r_dly--;
                busy = glitch && ($urandom_range(0, 15) == 0);
            end else if (r_len > 0) begin
                busy = 1'b1;
                r_len--;
            end else busy = glitch && ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && !model_idle(); i++) tick();
        repeat (3) tick();
        chk("drain_state_idle", int'(dut.state_q), 0);
    endtask

    task automatic wait_sent(input int n);
        for (int i = 0; i < 200 && sent.size() < n; i++) tick();
        chk("wait_sent_count", sent.size(), n);
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
    endtask

    logic [7:0] exp_rr [4] = '{8'h10, 8'h20, 8'h11, 8'h21};
    logic [7:0] exp_p [5]  = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h55};
    int k, n0;

    initial begin
        #2 rst_in = 1'b0;
        repeat (2) tick();
        chk("rst_txData", txData, 8'h00);
        chk("rst_full1", full1, 1'b0);
        rst_in = 1'b1;
        tick();
        chk("rst_txStart", txStart, 1'b0);

        // Single byte: start two edges after the push.
        sent.delete();
        wr0 = 1'b1; d0 = 8'h41;
        tick();
        wr0 = 1'b0;
        @(posedge clk); #1;
        chk("t1_start_early", txStart, 1'b0);
        @(posedge clk); #1;
        chk("t1_start", txStart, 1'b1);
        chk("t1_data", txData, 8'h41);
        repeat (3) tick();
        busy = 1'b1;
        repeat (10) tick();
        busy = 1'b0;
        repeat (3) tick();
        chk("t1_count", sent.size(), 1);
        chk("t1_idle", int'(dut.state_q), 0);
        chk("t1_err", timeoutErr, 1'b0);

        // Round-robin from reset.
        do_reset();
        busy = 1'b1;
        tick();
        wr0 = 1'b1; d0 = 8'h10; wr1 = 1'b1; d1 = 8'h20;
        tick();
        d0 = 8'h11; d1 = 8'h21;
        tick();
        wr0 = 1'b0; wr1 = 1'b0;
        sent.delete();
        auto_busy = 1;
        drain();
        chk("t2_count", sent.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_order", sent[i], exp_rr[i]);
        clear_flags();

        // Overflow on requester 1.
        auto_busy = 0; busy = 1'b1;
        sent.delete();
        for (int j = 0; j < 5; j++) begin
            tick();
            wr1 = 1'b1; d1 = 8'h61 + 8'(j);
            tick();
            wr1 = 1'b0;
            chk("t3_full1", full1, j >= 3);
            chk("t3_ovf1", ovf1, j == 4);
        end
        clear_flags();
        chk("t3_ovf1_clr", ovf1, 1'b0);
        chk("t3_full1_hold", full1, 1'b1);
        auto_busy = 1;
        drain();
        chk("t3_count", sent.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_bytes", sent[i], 8'h61 + 8'(i));
        clear_flags();

        // Push into full FIFO 0 during its LOAD cycle.
        auto_busy = 0; busy = 1'b1;
        sent.delete();
        for (int j = 0; j < 4; j++) begin
            wr0 = 1'b1; d0 = 8'h71 + 8'(j);
            tick();
        end
        wr0 = 1'b0;
        tick();
        chk("t4_full0", full0, 1'b1);
        busy = 1'b0;
        tick();
        wr0 = 1'b1; d0 = 8'h55;
        tick();
        wr0 = 1'b0;
        chk("t4_ovf0", ovf0, 1'b0);
        chk("t4_full0_kept", full0, 1'b1);
        auto_busy = 1;
        drain();
        chk("t4_count", sent.size(), 5);
        for (int i = 0; i < 5; i++) chk("t4_order", sent[i], exp_p[i]);
        clear_flags();

        // Acknowledge timeout.
        auto_busy = 0; busy = 1'b0;
        sent.delete();
        tick();
        wr0 = 1'b1; d0 = 8'h81;
        tick();
        d0 = 8'h82;
        tick();
        wr0 = 1'b0;
        for (int i = 0; i < 10 && txStart !== 1'b1; i++) tick();
        chk("t5_start", txStart, 1'b1);
        for (k = 0; k < 40 && timeoutErr !== 1'b1; k++) tick();
        chk("t5_latency", k, ACK_TIMEOUT);
        chk("t5_idle", int'(dut.state_q), 0);
        wait_sent(2);
        chk("t5_next_byte", sent[1], 8'h82);
        drain();
        clear_flags();
        chk("t5_err_clr", timeoutErr, 1'b0);

        // Asynchronous reset in WAIT_DONE with three bytes queued.
        sent.delete();
        tick();
        wr0 = 1'b1; d0 = 8'h91;
        tick();
        wr0 = 1'b0;
        for (int i = 0; i < 10 && txStart !== 1'b1; i++) tick();
        busy = 1'b1;
        tick();
        wr1 = 1'b1; d1 = 8'h92;
        tick();
        d1 = 8'h93;
        tick();
        d1 = 8'h94;
        tick();
        wr1 = 1'b0;
        tick();
        chk("t6_wait_done", int'(dut.state_q), 3);
        chk("t6_data_before", txData, 8'h91);
        n0 = sent.size();
        #2 rst_in = 1'b0;
        #1;
        chk("t6_rst_data", txData, 8'h00);
        chk("t6_rst_start", txStart, 1'b0);
        chk("t6_rst_state", int'(dut.state_q), 0);
        chk("t6_rst_full1", full1, 1'b0);
        repeat (2) tick();
        rst_in = 1'b1; busy = 1'b0;
        repeat (30) tick();
        chk("t6_no_start", sent.size(), n0);

        // Randomized traffic with busy glitches and occasional clears.
        auto_busy = 1; glitch = 1;
        repeat (3000) begin
            tick();
            wr0 = $urandom_range(0, 3) == 0; d0 = 8'($urandom);
            wr1 = $urandom_range(0, 3) == 0; d1 = 8'($urandom);
            clr = $urandom_range(0, 60) == 0;
        end
        wr0 = 1'b0; wr1 = 1'b0; clr = 1'b0; glitch = 0;
        drain();
        clear_flags();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-requester FIFO depth in bytes (power of 2, 2..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, max cycles to wait for txBusy rise after txStart.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wrData0  input  8  byte from requester 0 (RX echo path).
REQ-006 SHALL have port wrEn0  input  1  one-cycle push strobe for requester 0.
REQ-007 SHALL have port wrData1  input  8  byte from requester 1 (CPU port).
REQ-008 SHALL have port wrEn1  input  1  one-cycle push strobe for requester 1.
REQ-009 SHALL have port txBusy  input  1  transmitter busy flag from the RS232 transmitter.
REQ-010 SHALL have port txData  output  8  byte presented to the transmitter.
REQ-011 SHALL have port txStart  output  1  one-cycle, registered start pulse to the transmitter.
REQ-012 SHALL have port full0, full1  output  1 each  FIFO n holds DEPTH bytes.
REQ-013 SHALL have port ovf0, ovf1  output  1 each  sticky overflow flag for FIFO n.
REQ-014 SHALL have port ovfClr  input  1  clears both overflow flags.
REQ-015 SHALL have port timeoutErr  output  1  sticky; transmitter never acknowledged; cleared by ovfClr.

Function
REQ-016 SHALL accept a push into FIFO n when wrEnn=1 and (count<DEPTH or FIFO n pops in the same cycle).
REQ-017 SHALL drop a push that is not accepted, leave FIFO contents unchanged, and set ovfn the next cycle.
REQ-018 SHALL give ovfClr priority over a same-cycle overflow set (flag reads 0 afterwards).
REQ-019 SHALL implement FSM states IDLE, LOAD, WAIT_ACK, WAIT_DONE.
REQ-020 IDLE: SHALL go to LOAD when any FIFO is non-empty and txBusy=0; otherwise it stays in IDLE.
REQ-021 Grant on IDLE->LOAD SHALL be round-robin: if both non-empty, choose the FIFO not granted last; if one is non-empty, choose it; lastGrant resets to 1, so FIFO 0 wins the first contest.
REQ-022 LOAD (exactly one cycle): SHALL register txData<=head of granted FIFO, assert txStart=1, pop that FIFO, update lastGrant, then go to WAIT_ACK.
REQ-023 WAIT_ACK: SHALL go to WAIT_DONE on txBusy=1; after ACK_TIMEOUT cycles without it, SHALL set timeoutErr and return to IDLE. The byte is lost and is not retried.
REQ-024 WAIT_DONE: SHALL return to IDLE on txBusy=0.
REQ-025 SHALL hold txStart=0 in every state except LOAD, and SHALL hold txData stable until the next LOAD.
REQ-026 Latency: a push at edge N into an empty system with txBusy=0 SHALL produce txStart=1 during cycle N+2 (IDLE samples at N+1; LOAD registers at N+2).
REQ-027 FIFO pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits; output ordering per FIFO SHALL be strictly FIFO.
REQ-028 A push into the FIFO being popped in LOAD SHALL be accepted, with count unchanged, even when full.
REQ-029 Both FIFOs SHALL accept pushes in every FSM state.
REQ-030 A txBusy glitch in IDLE SHALL have no effect other than delaying the next grant.

Reset
REQ-031 On rst_in=0, SHALL asynchronously force: FSM to IDLE; both FIFOs empty (pointers and counts 0); txData=8'h00; txStart=0; full0=full1=0; ovf0=ovf1=0; timeoutErr=0; lastGrant=1; timeout counter 0.
REQ-032 Reset mid-transfer SHALL discard the in-flight byte and all queued bytes; no txStart is issued until a new push follows reset release.
REQ-033 FIFO storage contents need not be reset; only pointers and counts are reset.

Verification
REQ-034 Single byte: push 8'h41 on req0, transmitter model raises txBusy 3 cycles after txStart for 10 cycles -> one txStart 2 cycles after the push, txData=8'h41, FSM back in IDLE.
REQ-035 Round-robin: preload req0 with 8'h10,8'h11 and req1 with 8'h20,8'h21 while txBusy=1, then release -> output order 10,20,11,21.
REQ-036 Overflow: DEPTH=4, hold txBusy=1, push 5 bytes on req1 -> full1=1 after the 4th push, ovf1=1 after the 5th, 5th byte never sent; ovfClr -> ovf1=0.
REQ-037 Push while popping full FIFO: FIFO0 full, push 8'h55 in the LOAD cycle of FIFO0 -> accepted, ovf0 stays 0, 8'h55 sent last.
REQ-038 Timeout: txBusy tied 0 -> timeoutErr=1 exactly ACK_TIMEOUT cycles after txStart, FSM in IDLE; the next queued byte is still sent.
REQ-039 Async reset: assert rst_in=0 during WAIT_DONE with 3 bytes queued -> outputs reach reset values without a clock edge; no txStart after release.
